// File: rtl/song_ram_if.sv
// Song RAM bus between the record/playback sequencer (master) and the RAM (slave).
// Write data and read data are both packed as {delta, note}.
interface song_ram_if #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned NOTE_WIDTH  = 6,
  parameter int unsigned DELTA_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0]             ram_addr;
  logic                              ram_wr_en;
  logic [DELTA_WIDTH+NOTE_WIDTH-1:0] ram_wr_data;
  logic [DELTA_WIDTH+NOTE_WIDTH-1:0] ram_rd_data;

  modport master (output ram_addr, ram_wr_en, ram_wr_data, input ram_rd_data);
  modport slave  (input ram_addr, ram_wr_en, ram_wr_data, output ram_rd_data);
endinterface

// File: rtl/song_record_sequencer.sv
// Records timestamped note events into the song RAM and replays them with original timing.
// Optional LOOP_PLAYBACK_EN: restart the song from event 0 after each play_done.
module song_record_sequencer #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned NOTE_WIDTH  = 6,
  parameter int unsigned DELTA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            state,
  input  logic                  done_recording,
  input  logic                  tick,
  input  logic                  note_valid,
  input  logic [NOTE_WIDTH-1:0] note_in,
  song_ram_if.master            ram,
  output logic                  finished_recording,
  output logic [ADDR_WIDTH:0]   song_length,
  output logic                  play_note_valid,
  output logic [NOTE_WIDTH-1:0] play_note,
  output logic                  play_done
);
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [DELTA_WIDTH-1:0] DELTA_MAX = '1;

  typedef enum logic [2:0] {
    IDLE, REC, REC_FULL, PLAY_FETCH, PLAY_LATCH, PLAY_WAIT, PLAY_END
  } fsm_t;

  fsm_t                   fsm;
  logic [1:0]             mode_q;
  logic [CNT_W-1:0]       wr_ptr;
  logic [DELTA_WIDTH-1:0] rec_delta;
  logic [CNT_W-1:0]       rd_idx;
  logic [DELTA_WIDTH-1:0] pb_delta;
  logic [NOTE_WIDTH-1:0]  pb_note;
  logic [DELTA_WIDTH-1:0] tick_cnt;

  logic [1:0]       mode_c;
  logic             mode_change_c;
  logic [CNT_W-1:0] len_c;
  logic [CNT_W-1:0] rd_next_c;

  // Mode 11 behaves as JAM_SESH; leaving a record state commits the write count.
  assign mode_c        = (state == 2'b11) ? 2'b00 : state;
  assign mode_change_c = (mode_c != mode_q);
  assign len_c         = (fsm == REC || fsm == REC_FULL) ? wr_ptr : song_length;
  assign rd_next_c     = rd_idx + CNT_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm                <= IDLE;
      mode_q             <= 2'b00;
      wr_ptr             <= '0;
      rec_delta          <= '0;
      rd_idx             <= '0;
      pb_delta           <= '0;
      pb_note            <= '0;
      tick_cnt           <= '0;
      ram.ram_addr       <= '0;
      ram.ram_wr_en      <= 1'b0;
      ram.ram_wr_data    <= '0;
      finished_recording <= 1'b0;
      song_length        <= '0;
      play_note_valid    <= 1'b0;
      play_note          <= '0;
      play_done          <= 1'b0;
    end else begin
      mode_q          <= mode_c;
      ram.ram_wr_en   <= 1'b0;
      play_note_valid <= 1'b0;
      play_done       <= 1'b0;
      // The write strobe for the last slot is visible one cycle before this pulse.
      finished_recording <= ram.ram_wr_en && (ram.ram_addr == LAST_ADDR) && !mode_change_c;

      if (mode_change_c) begin
        song_length <= len_c;
        case (mode_c)
          2'b01: begin
            fsm       <= REC;
            wr_ptr    <= '0;
            rec_delta <= '0;
          end
          2'b10: begin
            rd_idx       <= '0;
            ram.ram_addr <= '0;
            if (len_c == '0) begin
              fsm       <= PLAY_END;
              play_done <= 1'b1;
            end else begin
              fsm <= PLAY_FETCH;
            end
          end
          default: fsm <= IDLE;
        endcase
      end else begin
        case (fsm)
          REC: begin
            if (note_valid) begin
              ram.ram_wr_en   <= 1'b1;
              ram.ram_addr    <= wr_ptr[ADDR_WIDTH-1:0];
              ram.ram_wr_data <= {rec_delta, note_in};
              wr_ptr          <= wr_ptr + CNT_W'(1);
              rec_delta       <= DELTA_WIDTH'(tick);
              if (wr_ptr == CNT_W'(DEPTH - 1)) fsm <= REC_FULL;
            end else if (tick && rec_delta != DELTA_MAX) begin
              rec_delta <= rec_delta + DELTA_WIDTH'(1);
            end
            if (done_recording) begin
              song_length <= wr_ptr + CNT_W'(note_valid);
              fsm         <= IDLE;
            end
          end
          REC_FULL: begin
            if (done_recording) begin
              song_length <= wr_ptr;
              fsm         <= IDLE;
            end
          end
          PLAY_FETCH: fsm <= PLAY_LATCH;
          PLAY_LATCH: begin
            {pb_delta, pb_note} <= ram.ram_rd_data;
            tick_cnt            <= '0;
            fsm                 <= PLAY_WAIT;
          end
          PLAY_WAIT: begin
            if (tick_cnt == pb_delta) begin
              play_note_valid <= 1'b1;
              play_note       <= pb_note;
              rd_idx          <= rd_next_c;
              if (rd_next_c == song_length) begin
                play_done <= 1'b1;
`ifdef LOOP_PLAYBACK_EN
                rd_idx       <= '0;
                ram.ram_addr <= '0;
                fsm          <= PLAY_FETCH;
`else
                fsm <= PLAY_END;
`endif
              end else begin
                ram.ram_addr <= rd_next_c[ADDR_WIDTH-1:0];
                fsm          <= PLAY_FETCH;
              end
            end else if (tick) begin
              tick_cnt <= tick_cnt + DELTA_WIDTH'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: doc/song_record_sequencer.md
Name: song_record_sequencer

Overview:
- Sequences the song RAM behind the top-level mode controller.
- In COMPOSER mode it records timestamped note events into the RAM. In SONG_PLAYER mode it reads them back and replays them with the original timing.
- Drives the finished_recording input of the mode controller when the RAM fills.

Parameters:
ADDR_WIDTH, 10, RAM depth = 2^ADDR_WIDTH events
NOTE_WIDTH, 6, note number width (0 = rest/release)
DELTA_WIDTH, 16, inter-event tick count width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
state  in  2  mode from controller: 00 JAM_SESH, 01 COMPOSER, 10 SONG_PLAYER, 11 treated as JAM_SESH
done_recording  in  1  one-cycle pulse: recording ended by user or RAM full
tick  in  1  one-cycle timebase strobe
note_valid  in  1  one-cycle pulse: new note event
note_in  in  NOTE_WIDTH  note number, qualified by note_valid
ram_addr  out  ADDR_WIDTH  RAM address (write in record, read in playback)
ram_wr_en  out  1  RAM write strobe
ram_wr_data  out  DELTA_WIDTH+NOTE_WIDTH  {delta, note}
ram_rd_data  in  DELTA_WIDTH+NOTE_WIDTH  read data, valid exactly 1 cycle after ram_addr
finished_recording  out  1  one-cycle pulse after the final RAM slot is written
song_length  out  ADDR_WIDTH+1  number of stored events
play_note_valid  out  1  one-cycle pulse: replayed note
play_note  out  NOTE_WIDTH  replayed note, held until next event
play_done  out  1  one-cycle pulse at end of song

Behaviour:
- Reset (reset low, async): FSM to IDLE; all outputs 0; song_length 0; counters 0.
- FSM states: IDLE, REC, REC_FULL, PLAY_FETCH, PLAY_LATCH, PLAY_WAIT, PLAY_END.
- Mode-change rule: any change of state forces IDLE on the next edge, with no further writes or play pulses.
  - Entering 01 moves to REC.
  - Entering 10 moves to PLAY_FETCH, or to PLAY_END if song_length==0.

REC:
- On entry: wr_ptr=0, delta=0.
- tick increments delta, saturating at 2^DELTA_WIDTH-1.
- On note_valid, in the same cycle:
  - ram_wr_en=1, ram_addr=wr_ptr, ram_wr_data={delta,note_in}.
  - wr_ptr++.
  - delta becomes 0, or 1 if tick is also high.
- Write to the last slot (wr_ptr==2^ADDR_WIDTH-1): go to REC_FULL and pulse finished_recording on the next cycle.
- REC_FULL ignores note_valid.
- On done_recording, or when leaving 01 from REC or REC_FULL:
  - song_length <= number of writes made, 0 to 2^ADDR_WIDTH.
  - A note_valid coincident with done_recording is still written and counted.
- song_length is otherwise stable and survives mode changes.

Playback:
- PLAY_FETCH: ram_addr=rd_idx (0 on entry), go to PLAY_LATCH.
- PLAY_LATCH: capture {delta,note} from ram_rd_data, clear tick counter, go to PLAY_WAIT.
- PLAY_WAIT: count ticks. When count==delta:
  - Pulse play_note_valid and update play_note.
  - delta==0 fires in the first PLAY_WAIT cycle.
  - rd_idx++.
  - If rd_idx+1==song_length: pulse play_done in the same cycle and go to PLAY_END. Otherwise go to PLAY_FETCH.
- Minimum spacing between consecutive play pulses is 3 cycles.
- PLAY_END: no outputs; holds until the mode changes. If song_length==0, play_done pulses once on entry.
- ram_wr_en is never asserted outside REC.

Optional Feature:
LOOP_PLAYBACK_EN
- Defined: at end of song, play_done still pulses, then rd_idx=0 and the FSM goes to PLAY_FETCH, repeating until the mode changes. Zero-length songs still go to PLAY_END.
- Undefined: playback stops in PLAY_END as described above.

Test Plan (ADDR_WIDTH=3):
- Record, then play back: enter 01; send notes 28, 30, 32 with 0/5/2 ticks between events; pulse done_recording. Required: RAM holds {0,28},{5,30},{2,32}; song_length=3. Then enter 10: play pulses 28, 30, 32 at tick gaps 0/5/2, then one play_done pulse.
- RAM full: enter 01; send 8 notes. Required: finished_recording pulses once, the cycle after the write to addr 7. A 9th note is not written. After done_recording, song_length=8.
- Simultaneous events: note_valid and tick in the same cycle. Required: delta written excludes that tick; the next event's delta counts it (value 1 with no further ticks).
- Mode change mid-operation: switch from 10 to 00 during PLAY_WAIT. Required: no play_note_valid or play_done afterward; FSM in IDLE. Re-entering 10 restarts from event 0.
- Reset mid-operation: assert reset low mid-REC. Required: all outputs 0 immediately and song_length=0; entering 10 afterward gives play_done with no notes.
- LOOP_PLAYBACK_EN, song of 2 notes: required pattern is note, note, play_done, note, note, play_done, ... until the mode leaves 10.
